// File: rtl/video_timing_pattern_gen_pkg.sv
// video_pkg: shared pixel/pattern types, colour-bar table and frame geometry helpers
// for the video timing pattern generator.
package video_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {PM_SOLID, PM_BARS, PM_GRAD, PM_CHECK} pattern_mode_e;

    localparam rgb_t BAR_RGB [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic int frame_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    // Counters are at least 8 bits wide so the gradient can always slice [7:0].
    function automatic int cnt_w(input int total);
        return $clog2(total) < 8 ? 8 : $clog2(total);
    endfunction

endpackage

// File: rtl/video_timing_pattern_gen_if.sv
// video_timing_pattern_gen_if: DVI-receiver-compatible output bundle.
interface video_timing_pattern_gen_if;
    logic [3:0]  pll_phase;
    logic        pll_phase_lock;
    logic        rgb_clk;
    logic        rgb_vs;
    logic        rgb_hs;
    logic        rgb_de;
    logic [7:0]  rgb_r;
    logic [7:0]  rgb_g;
    logic [7:0]  rgb_b;
    logic [15:0] frame_cnt;

    modport master (output pll_phase, pll_phase_lock, rgb_clk, rgb_vs, rgb_hs, rgb_de,
                    rgb_r, rgb_g, rgb_b, frame_cnt);
    modport slave  (input  pll_phase, pll_phase_lock, rgb_clk, rgb_vs, rgb_hs, rgb_de,
                    rgb_r, rgb_g, rgb_b, frame_cnt);
endinterface

// File: rtl/video_timing_pattern_gen_core.sv
// video_timing_core: lock delay, h/v counters, registered sync/de decode and frame count.
module video_timing_core
    import video_pkg::*;
#(
    parameter int H_ACTIVE   = 128,
    parameter int H_FP       = 4,
    parameter int H_SYNC     = 8,
    parameter int H_BP       = 4,
    parameter int V_ACTIVE   = 32,
    parameter int V_FP       = 2,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 3,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1,
    parameter int LOCK_DELAY = 16,
    localparam int HT = frame_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int VT = frame_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HW = cnt_w(HT),
    localparam int VW = cnt_w(VT)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_enable,
    output logic          o_run,
    output logic          o_first,
    output logic          o_h_last,
    output logic          o_act,
    output logic [HW-1:0] o_h,
    output logic [VW-1:0] o_v,
    output logic          o_lock,
    output logic          o_de,
    output logic          o_hs,
    output logic          o_vs,
    output logic [15:0]   o_frame_cnt
);
    localparam int LW = $clog2(LOCK_DELAY + 1);

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic [LW-1:0] r_lock_cnt;
    logic [15:0]   r_frame;
    logic          r_lock, r_de, r_hs, r_vs;
    logic          w_run, w_h_last, w_v_last, w_act, w_hs_act, w_vs_act;

    assign w_run    = r_lock && i_enable;
    assign w_h_last = r_h == HW'(HT - 1);
    assign w_v_last = r_v == VW'(VT - 1);
    assign w_act    = r_h < HW'(H_ACTIVE) && r_v < VW'(V_ACTIVE);
    assign w_hs_act = r_h >= HW'(H_ACTIVE + H_FP) && r_h < HW'(H_ACTIVE + H_FP + H_SYNC);
    assign w_vs_act = r_v >= VW'(V_ACTIVE + V_FP) && r_v < VW'(V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock_cnt <= '0;
            r_lock     <= 1'b0;
            r_h        <= '0;
            r_v        <= '0;
            r_frame    <= '0;
            r_de       <= 1'b0;
            r_hs       <= !HS_POL;
            r_vs       <= !VS_POL;
        end else begin
            if (!r_lock) begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
                r_lock     <= r_lock_cnt == LW'(LOCK_DELAY - 1);
            end
            r_h  <= (w_run && !w_h_last) ? r_h + 1'b1 : '0;
            r_v  <= !w_run ? '0 : !w_h_last ? r_v : w_v_last ? '0 : r_v + 1'b1;
            if (w_run && w_h_last && w_v_last)
                r_frame <= r_frame + 16'd1;
            r_de <= w_run && w_act;
            r_hs <= (w_run && w_hs_act) ? HS_POL : !HS_POL;
            r_vs <= (w_run && w_vs_act) ? VS_POL : !VS_POL;
        end
    end

    assign o_run       = w_run;
    assign o_first     = w_run && r_h == '0 && r_v == '0;
    assign o_h_last    = w_h_last;
    assign o_act       = w_act;
    assign o_h         = r_h;
    assign o_v         = r_v;
    assign o_lock      = r_lock;
    assign o_de        = r_de;
    assign o_hs        = r_hs;
    assign o_vs        = r_vs;
    assign o_frame_cnt = r_frame;
endmodule

// File: rtl/video_timing_pattern_gen.sv
// video_timing_pattern_gen: programmable video timing plus test-pattern source,
// presenting the same output bundle as the DVI receiver.
module video_timing_pattern_gen
    import video_pkg::*;
#(
    parameter int         H_ACTIVE   = 128,
    parameter int         H_FP       = 4,
    parameter int         H_SYNC     = 8,
    parameter int         H_BP       = 4,
    parameter int         V_ACTIVE   = 32,
    parameter int         V_FP       = 2,
    parameter int         V_SYNC     = 3,
    parameter int         V_BP       = 3,
    parameter bit         HS_POL     = 1'b1,
    parameter bit         VS_POL     = 1'b1,
    parameter int         LOCK_DELAY = 16,
    parameter logic [3:0] PHASE      = 4'd0
) (
    input  logic                              I_clk,
    input  logic                              I_rst_n,
    input  logic                              I_enable,
    input  logic [1:0]                        I_mode,
    input  logic [23:0]                       I_solid_rgb,
    video_timing_pattern_gen_if.master        O_vid
);
    localparam int HW = cnt_w(frame_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int VW = cnt_w(frame_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam int BW = $clog2(H_ACTIVE / 8 + 1);

    if (H_ACTIVE % 8 != 0 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || LOCK_DELAY < 1) begin : g_bad_params
        $error("video_timing_pattern_gen: invalid geometry parameters");
    end

    logic [HW-1:0]  w_h;
    logic [VW-1:0]  w_v;
    logic [15:0]    w_frame;
    logic           w_run, w_first, w_h_last, w_act;
    pattern_mode_e  w_mode, r_mode;
    rgb_t           w_solid, w_pix, r_solid, r_rgb;
    logic [BW-1:0]  r_bar_px;
    logic [2:0]     r_bar_idx;

    video_timing_core #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .LOCK_DELAY(LOCK_DELAY)
    ) u_core (
        .i_clk(I_clk), .i_rst_n(I_rst_n), .i_enable(I_enable),
        .o_run(w_run), .o_first(w_first), .o_h_last(w_h_last), .o_act(w_act),
        .o_h(w_h), .o_v(w_v), .o_lock(O_vid.pll_phase_lock),
        .o_de(O_vid.rgb_de), .o_hs(O_vid.rgb_hs), .o_vs(O_vid.rgb_vs),
        .o_frame_cnt(w_frame)
    );

    // The first pixel of a frame already uses the freshly sampled mode/colour.
    always_comb begin
        w_mode  = w_first ? pattern_mode_e'(I_mode) : r_mode;
        w_solid = w_first ? rgb_t'(I_solid_rgb) : r_solid;
        w_pix   = w_mode == PM_SOLID ? w_solid :
                  w_mode == PM_BARS  ? BAR_RGB[r_bar_idx] :
                  w_mode == PM_GRAD  ? rgb_t'({w_h[7:0], w_v[7:0], w_frame[7:0]}) :
                  (w_h[3] ^ w_v[3])  ? rgb_t'(24'hFFFFFF) : rgb_t'(24'h000000);
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_mode    <= PM_SOLID;
            r_solid   <= '0;
            r_rgb     <= '0;
            r_bar_px  <= '0;
            r_bar_idx <= '0;
        end else begin
            if (w_first) begin
                r_mode  <= w_mode;
                r_solid <= w_solid;
            end
            r_rgb <= (w_run && w_act) ? w_pix : '0;
            if (!w_run || w_h_last) begin
                r_bar_px  <= '0;
                r_bar_idx <= '0;
            end else if (r_bar_px == BW'(H_ACTIVE / 8 - 1)) begin
                r_bar_px  <= '0;
                r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
                r_bar_px  <= r_bar_px + 1'b1;
            end
        end
    end

    assign O_vid.pll_phase = PHASE;
    assign O_vid.rgb_clk   = I_clk;
    assign O_vid.rgb_r     = r_rgb.r;
    assign O_vid.rgb_g     = r_rgb.g;
    assign O_vid.rgb_b     = r_rgb.b;
    assign O_vid.frame_cnt = w_frame;
endmodule
